upscale_index_counter: RTL and testbench

// - Parametrised two-level modulo counter: generalises the fixed mod-3 enable counter.
// - Adds runtime modulus, cascade, start/done and valid/ready control.
// - Walks source index 0..len-1 and repeats each index `scale` times (replication phase 0..scale-1).
// - Drives pixel/line replication addressing in the upscaler datapath; one instance per axis.

---
 rtl/upscale_index_counter_pkg.sv | 4 +
 rtl/upscale_index_counter_mod_counter.sv | 23 ++
 rtl/upscale_index_counter.sv | 58 +++++
 tb/tb_upscale_index_counter.sv | 118 +++++++++++
 4 files changed

// File: rtl/upscale_index_counter_pkg.sv
// upscale_index_counter_pkg: FSM state encoding shared by the upscaler index counter
package upscale_index_counter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/upscale_index_counter_mod_counter.sv
// mod_counter: runtime-modulus counter with enable, sync clear and terminal count (q==mod-1)
module mod_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] mod,
  output logic [W-1:0] q,
  output logic         tc
);
  logic [W-1:0] q_q, q_d;
  always_comb begin
    tc = q_q == mod - W'(1);
    q_d = clr ? '0 : en ? (tc ? '0 : q_q + W'(1)) : q_q;
  end
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/upscale_index_counter.sv
// upscale_index_counter: walks source index 0..len-1, repeating each index scale times
module upscale_index_counter
  import upscale_index_counter_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int PH_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PH_W-1:0]  scale_in,
  input  logic [IDX_W-1:0] len_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [PH_W-1:0]  out_phase,
  output logic             out_first,
  output logic             out_last,
  output logic             done
);
  state_e           state_q, state_d;
  logic [PH_W-1:0]  scale_q, scale_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic             accept, beat, ph_tc, idx_tc;
  always_comb begin
    accept  = state_q == IDLE && start;
    beat    = state_q == RUN && out_ready;
    scale_d = accept ? (scale_in == '0 ? PH_W'(1) : scale_in) : scale_q;
    len_d   = accept ? len_in : len_q;
    state_d = state_q == IDLE ? (!start ? IDLE : len_in != '0 ? RUN : DONE)
            : state_q == RUN  ? (beat && ph_tc && idx_tc ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scale_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      scale_q <= scale_d;
      len_q   <= len_d;
    end
  end
  // both counters wrap to zero on the final beat, so idle outputs read (0,0)
  mod_counter #(.W(PH_W)) u_phase (
    .clk(clk), .rst(rst), .en(beat), .clr(accept), .mod(scale_q), .q(out_phase), .tc(ph_tc)
  );
  mod_counter #(.W(IDX_W)) u_idx (
    .clk(clk), .rst(rst), .en(beat && ph_tc), .clr(accept), .mod(len_q), .q(out_idx), .tc(idx_tc)
  );
  assign busy      = state_q == RUN;
  assign out_valid = busy;
  assign out_first = busy && out_phase == '0;
  assign out_last  = busy && ph_tc && idx_tc;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_upscale_index_counter.sv
// tb_upscale_index_counter: directed scoreboard bench for the upscaler index counter
module tb_upscale_index_counter;
  logic       clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [2:0] scale_in = '0, out_phase;
  logic [9:0] len_in = '0, out_idx;
  logic       busy, out_valid, out_first, out_last, done;
  int total = 0, bad = 0;
  typedef struct packed {logic [9:0] idx; logic [2:0] ph; logic f; logic l;} beat_t;
  beat_t sb[$];
  upscale_index_counter dut (
    .clk(clk), .rst(rst), .start(start), .scale_in(scale_in), .len_in(len_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_phase(out_phase), .out_first(out_first), .out_last(out_last), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " valid"}, 32'(out_valid), 0);
    check({tag, " idx"}, 32'(out_idx), 0);
    check({tag, " phase"}, 32'(out_phase), 0);
    check({tag, " first"}, 32'(out_first), 0);
    check({tag, " last"}, 32'(out_last), 0);
    check({tag, " done"}, 32'(done), 0);
  endtask
  task automatic push_run(input int sc, input int ln);
    int eff;
    eff = sc == 0 ? 1 : sc;
    for (int i = 0; i < ln; i++)
      for (int p = 0; p < eff; p++)
        sb.push_back({10'(i), 3'(p), p == 0, i == ln - 1 && p == eff - 1});
  endtask
  // consume up to max_beats scoreboard entries; stall_n idle cycles inserted at beat stall_at
  task automatic drain(input string tag, input int max_beats, input int stall_at, input int stall_n);
    int n, stalled, cyc;
    beat_t e;
    n = 0; stalled = 0; cyc = 0;
    while (sb.size() > 0 && n < max_beats && cyc < 5000) begin
      e = sb[0];
      out_ready = !(n == stall_at && stalled < stall_n);
      check({tag, " valid"}, 32'(out_valid), 1);
      check({tag, " idx"}, 32'(out_idx), 32'(e.idx));
      check({tag, " phase"}, 32'(out_phase), 32'(e.ph));
      check({tag, " first"}, 32'(out_first), 32'(e.f));
      check({tag, " last"}, 32'(out_last), 32'(e.l));
      if (out_ready) begin
        void'(sb.pop_front());
        n++;
      end else stalled++;
      tick();
      cyc++;
    end
    check({tag, " beat budget"}, 32'(cyc < 5000), 1);
  endtask
  task automatic run(input string tag, input int sc, input int ln, input int stall_at,
                     input int stall_n, input bit disturb);
    push_run(sc, ln);
    scale_in = 3'(sc); len_in = 10'(ln); start = 1; out_ready = 1;
    tick();
    start = disturb;
    if (disturb) begin
      scale_in = 3'd5; len_in = 10'd7;
    end
    if (ln == 0) begin
      check({tag, " empty busy"}, 32'(busy), 0);
      check({tag, " empty done"}, 32'(done), 1);
    end else begin
      drain(tag, 1 << 20, stall_at, stall_n);
      check({tag, " end done"}, 32'(done), 1);
      check({tag, " end busy"}, 32'(busy), 0);
      check({tag, " end valid"}, 32'(out_valid), 0);
    end
    start = 0;
    tick();
    check_idle({tag, " after"});
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    check_idle("reset");
    run("s3l2", 3, 2, -1, 0, 0);
    run("s3l2 stall", 3, 2, 1, 3, 0);
    run("s0l4", 0, 4, -1, 0, 0);
    run("l0", 4, 0, -1, 0, 0);
    run("disturb", 2, 3, -1, 0, 1);
    run("s7l1", 7, 1, 2, 2, 0);
    push_run(7, 1023);
    scale_in = 3'd7; len_in = 10'd1023; start = 1; out_ready = 1;
    tick();
    start = 0;
    drain("s7l1023", 3, -1, 0);
    check("pre-rst idx", 32'(out_idx), 0);
    check("pre-rst phase", 32'(out_phase), 3);
    sb.delete();
    rst = 1;
    tick();
    rst = 0;
    check_idle("mid rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no done after rst", 32'(done), 0);
      check("idle after rst", 32'(busy), 0);
    end
    run("after rst", 2, 2, -1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
